// File: rtl/sc_pscheck_pkg.sv
// Shared definitions for the pseudo-random sequence checker:
// FSM state encoding, LFSR polynomial taps and the next-word step.
package sc_pscheck_pkg;

  localparam int LFSR_W = 8;

  // x^8+x^6+x^5+x^4+1, feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] POLY_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_e;

  function automatic logic [LFSR_W-1:0] next_word(
    input logic [LFSR_W-1:0] w
  );
    return {w[LFSR_W-2:0], ^(w & POLY_TAPS)};
  endfunction

endpackage

// File: rtl/sc_satcounter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk_i, rst_ni, clear_i, incr_i, value_o[WIDTH].
module sc_satcounter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             incr_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (incr_i && (value_q != '1)) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sc_pscheck.sv
// Receive-side checker for the 8-bit LFSR word stream: hunts, verifies,
// locks, then flags/counts mismatches. Ports: clock, async reset_n,
// valid, data, clear_n in; locked, error pulse, saturating errcount out.
module sc_pscheck
  import sc_pscheck_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERRWIDTH     = 16
) (
  input  logic                 SC_PSCHECK_CLOCK_50,
  input  logic                 SC_PSCHECK_RESET_InLow,
  input  logic                 SC_PSCHECK_valid_InHigh,
  input  logic [DATAWIDTH-1:0] SC_PSCHECK_data_InBUS,
  input  logic                 SC_PSCHECK_clear_InLow,
  output logic                 SC_PSCHECK_locked_OutHigh,
  output logic                 SC_PSCHECK_error_OutHigh,
  output logic [ERRWIDTH-1:0]  SC_PSCHECK_errcount_OutBUS
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  logic                 clk;
  logic                 rst_n;
  logic                 valid;
  logic [DATAWIDTH-1:0] data;

  assign clk   = SC_PSCHECK_CLOCK_50;
  assign rst_n = SC_PSCHECK_RESET_InLow;
  assign valid = SC_PSCHECK_valid_InHigh;
  assign data  = SC_PSCHECK_data_InBUS;

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] pred_q, pred_d;
  logic [3:0]           run_q, run_d;
  logic                 err_q, err_d;
  logic                 locked_q;

  logic       hit;
  logic       zero;
  logic [3:0] run_inc;

  assign hit     = (data == pred_q);
  assign zero    = (data == '0);
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    run_d   = run_q;
    err_d   = 1'b0;
    if (valid) begin
      unique case (state_q)
        HUNT: begin
          if (!zero) begin
            pred_d  = next_word(data);
            run_d   = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            pred_d = next_word(data);
            run_d  = run_inc;
            if (run_inc == LOCK_N) begin
              state_d = LOCKED;
              run_d   = '0;
            end
          end else if (!zero) begin
            pred_d = next_word(data);
            run_d  = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so a bad word never reseeds.
          pred_d = next_word(pred_q);
          if (hit) begin
            run_d = '0;
          end else begin
            err_d = 1'b1;
            run_d = run_inc;
            if (run_inc == UNLOCK_N) begin
              state_d = HUNT;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      run_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      run_q    <= run_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  sc_satcounter #(
    .WIDTH (ERRWIDTH)
  ) u_errcnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (~SC_PSCHECK_clear_InLow),
    .incr_i  (err_d),
    .value_o (SC_PSCHECK_errcount_OutBUS)
  );

  assign SC_PSCHECK_locked_OutHigh = locked_q;
  assign SC_PSCHECK_error_OutHigh  = err_q;

endmodule

// File: tb/tb_sc_pscheck.sv
// Bench for sc_pscheck: two instances (default, and ERRWIDTH=2 /
// UNLOCK_COUNT=15) driven by the same stream, checked against a model.
module tb_sc_pscheck;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       clr_n = 1'b1;

  logic        lk_a, er_a, lk_b, er_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  logic        lk_w[2];
  logic        er_w[2];
  logic [15:0] cnt_w[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    lk_w[0]  = lk_a;
    lk_w[1]  = lk_b;
    er_w[0]  = er_a;
    er_w[1]  = er_b;
    cnt_w[0] = cnt_a;
    cnt_w[1] = {14'd0, cnt_b};
  end

  sc_pscheck #(
    .DATAWIDTH(8), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERRWIDTH(16)
  ) dut_a (
    .SC_PSCHECK_CLOCK_50        (clk),
    .SC_PSCHECK_RESET_InLow     (rst_n),
    .SC_PSCHECK_valid_InHigh    (valid),
    .SC_PSCHECK_data_InBUS      (data),
    .SC_PSCHECK_clear_InLow     (clr_n),
    .SC_PSCHECK_locked_OutHigh  (lk_a),
    .SC_PSCHECK_error_OutHigh   (er_a),
    .SC_PSCHECK_errcount_OutBUS (cnt_a)
  );

  sc_pscheck #(
    .DATAWIDTH(8), .LOCK_COUNT(4), .UNLOCK_COUNT(15), .ERRWIDTH(2)
  ) dut_b (
    .SC_PSCHECK_CLOCK_50        (clk),
    .SC_PSCHECK_RESET_InLow     (rst_n),
    .SC_PSCHECK_valid_InHigh    (valid),
    .SC_PSCHECK_data_InBUS      (data),
    .SC_PSCHECK_clear_InLow     (clr_n),
    .SC_PSCHECK_locked_OutHigh  (lk_b),
    .SC_PSCHECK_error_OutHigh   (er_b),
    .SC_PSCHECK_errcount_OutBUS (cnt_b)
  );

  // Reference model: mode 0 hunting, 1 verifying, 2 locked.
  int LC[2] = '{4, 4};
  int UC[2] = '{3, 15};
  int MX[2] = '{65535, 3};
  int m_mode[2];
  int m_p[2];
  int m_run[2];
  int m_cnt[2];
  bit m_err[2];
  bit m_lk[2];

  function automatic int nxt(input int w);
    int fb;
    fb = ((w >> 7) ^ (w >> 5) ^ (w >> 4) ^ (w >> 3)) & 1;
    return ((w * 2) % 256) + fb;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_p[i] = 0; m_run[i] = 0;
      m_cnt[i] = 0; m_err[i] = 0; m_lk[i] = 0;
    end
  endtask

  task automatic model_clk(input bit v, input int w, input bit clr);
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      if (v) begin
        if (m_mode[i] == 0) begin
          if (w != 0) begin
            m_p[i] = nxt(w); m_run[i] = 0; m_mode[i] = 1;
          end
        end else if (m_mode[i] == 1) begin
          if (w == m_p[i]) begin
            m_p[i] = nxt(w);
            m_run[i]++;
            if (m_run[i] == LC[i]) begin
              m_mode[i] = 2; m_run[i] = 0;
            end
          end else if (w != 0) begin
            m_p[i] = nxt(w); m_run[i] = 0;
          end else begin
            m_mode[i] = 0;
          end
        end else begin
          if (w == m_p[i]) begin
            m_run[i] = 0;
          end else begin
            m_err[i] = 1;
            if (m_cnt[i] < MX[i]) m_cnt[i]++;
            m_run[i]++;
            if (m_run[i] == UC[i]) m_mode[i] = 0;
          end
          m_p[i] = nxt(m_p[i]);
        end
      end
      if (clr) m_cnt[i] = 0;
      m_lk[i] = (m_mode[i] == 2);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] w, input bit clr);
    valid = v;
    data  = w;
    clr_n = ~clr;
    @(posedge clk);
    model_clk(v, int'(w), clr);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    clr_n = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_seq();
    logic [7:0] seq[5];
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    for (int k = 0; k < 5; k++) step(1'b1, seq[k], 1'b0);
  endtask

  task automatic test_reset();
    valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lk_w[i] !== 1'b0) begin
        errors++; $display("FAIL reset_locked[%0d]: got %b want 0", i, lk_w[i]);
      end
      checks++;
      if (er_w[i] !== 1'b0) begin
        errors++; $display("FAIL reset_error[%0d]: got %b want 0", i, er_w[i]);
      end
      checks++;
      if (cnt_w[i] !== 16'd0) begin
        errors++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt_w[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] seq[5];
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, seq[k], 1'b0);
      checks++;
      if (lk_a !== m_lk[0] || lk_a !== (k == 4)) begin
        errors++;
        $display("FAIL lock_locked step %0d: got %b want %b", k, lk_a, k == 4);
      end
      checks++;
      if (er_a !== 1'b0) begin
        errors++; $display("FAIL lock_error step %0d: got %b want 0", k, er_a);
      end
    end
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++; $display("FAIL lock_count: got %0d want 0", cnt_a);
    end
  endtask

  task automatic test_single_error();
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (er_a !== 1'b1 || cnt_a !== 16'd1 || lk_a !== 1'b1) begin
      errors++;
      $display("FAIL single_err: got err=%b cnt=%0d lk=%b want 1 1 1", er_a, cnt_a, lk_a);
    end
    step(1'b1, 8'h47, 1'b0);
    checks++;
    if (er_a !== 1'b0 || cnt_a !== 16'd1 || lk_a !== 1'b1) begin
      errors++;
      $display("FAIL single_ok: got err=%b cnt=%0d lk=%b want 0 1 1", er_a, cnt_a, lk_a);
    end
  endtask

  task automatic test_unlock();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h00, 1'b0);
      checks++;
      if (lk_a !== m_lk[0] || er_a !== 1'b1 || cnt_a !== 16'(m_cnt[0])) begin
        errors++;
        $display("FAIL unlock step %0d: got lk=%b err=%b cnt=%0d want %b 1 %0d",
                 k, lk_a, er_a, cnt_a, m_lk[0], m_cnt[0]);
      end
    end
    checks++;
    if (lk_a !== 1'b0 || cnt_a !== 16'd4) begin
      errors++; $display("FAIL unlock_final: got lk=%b cnt=%0d want 0 4", lk_a, cnt_a);
    end
    lock_seq();
    checks++;
    if (lk_a !== 1'b1) begin
      errors++; $display("FAIL relock: got %b want 1", lk_a);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] seq[4];
    seq = '{8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    repeat (4) step(1'b1, 8'h00, 1'b0);
    checks++;
    if (lk_a !== 1'b0 || lk_b !== 1'b0) begin
      errors++; $display("FAIL gaps_zero_seed: got %b %b want 0 0", lk_a, lk_b);
    end
    step(1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'($urandom), 1'b0);
      checks++;
      if (lk_a !== 1'b0) begin
        errors++; $display("FAIL gaps_early_lock %0d: got %b want 0", k, lk_a);
      end
      step(1'b1, seq[k], 1'b0);
    end
    checks++;
    if (lk_a !== 1'b1 || lk_b !== 1'b1 || er_a !== 1'b0) begin
      errors++;
      $display("FAIL gaps_lock: got %b %b err=%b want 1 1 0", lk_a, lk_b, er_a);
    end
  endtask

  task automatic test_saturate();
    int want[5];
    want = '{1, 2, 3, 3, 3};
    do_reset();
    lock_seq();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h00, 1'b0);
      checks++;
      if (cnt_b !== 2'(want[k]) || er_b !== 1'b1 || lk_b !== 1'b1) begin
        errors++;
        $display("FAIL sat step %0d: got cnt=%0d err=%b lk=%b want %0d 1 1",
                 k, cnt_b, er_b, lk_b, want[k]);
      end
    end
    step(1'b1, 8'h00, 1'b1);
    checks++;
    if (cnt_b !== 2'd0 || er_b !== 1'b1 || lk_b !== 1'b1) begin
      errors++;
      $display("FAIL clear_mismatch: got cnt=%0d err=%b lk=%b want 0 1 1", cnt_b, er_b, lk_b);
    end
    checks++;
    if (cnt_a !== 16'd0 || lk_a !== 1'b0) begin
      errors++; $display("FAIL clear_a: got cnt=%0d lk=%b want 0 0", cnt_a, lk_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_seq();
    step(1'b1, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (lk_a !== 1'b0 || er_a !== 1'b0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got lk=%b err=%b cnt=%0d want 0 0 0", lk_a, er_a, cnt_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    checks++;
    if (lk_a !== 1'b0) begin
      errors++; $display("FAIL post_reset_hunt: got %b want 0", lk_a);
    end
    step(1'b1, 8'h11, 1'b0);
    checks++;
    if (lk_a !== 1'b1) begin
      errors++; $display("FAIL post_reset_lock: got %b want 1", lk_a);
    end
  endtask

  task automatic test_random();
    int g;
    bit v;
    bit clr;
    logic [7:0] w;
    do_reset();
    g = int'($urandom_range(255, 1));
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom % 4) != 0;
      clr = ($urandom % 50) == 0;
      w   = 8'(g);
      if (v && ($urandom % 12) == 0) w = 8'($urandom);
      if (v) g = nxt(g);
      step(v, w, clr);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (lk_w[i] !== m_lk[i] || er_w[i] !== m_err[i] ||
            cnt_w[i] !== 16'(m_cnt[i])) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got lk=%b err=%b cnt=%0d want %b %b %0d",
                   i, n, lk_w[i], er_w[i], cnt_w[i], m_lk[i], m_err[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_gaps();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_pscheck.md
# sc_pscheck

Pseudo-random sequence checker: the receive end of the 8-bit LFSR word stream produced by the team's pseudo-random generator. Self-synchronises to an incoming word stream, predicts each next word, and declares lock after a run of correct predictions. Counts and flags mismatches while locked. Sits downstream of a link or loopback under test, with status and error count exported to board outputs or a register block.

## Interface
Parameters:
- DATAWIDTH, 8, word width; the polynomial is defined for 8 only.
- LOCK_COUNT, 4, consecutive correct predictions required to lock (1..15).
- UNLOCK_COUNT, 3, consecutive mismatches while locked that force re-hunt (1..15).
- ERRWIDTH, 16, error counter width.

Ports (reset is asynchronous, active-low):
- SC_PSCHECK_CLOCK_50, in, 1, system clock.
- SC_PSCHECK_RESET_InLow, in, 1, asynchronous active-low reset.
- SC_PSCHECK_valid_InHigh, in, 1, data word present this cycle.
- SC_PSCHECK_data_InBUS, in, DATAWIDTH, received word.
- SC_PSCHECK_clear_InLow, in, 1, synchronous clear of the error counter.
- SC_PSCHECK_locked_OutHigh, out, 1, checker locked.
- SC_PSCHECK_error_OutHigh, out, 1, one-cycle pulse per mismatched word while locked.
- SC_PSCHECK_errcount_OutBUS, out, ERRWIDTH, saturating mismatch count.

## Operation
- LFSR step function: next(w) = {w[6:0], w[7]^w[5]^w[4]^w[3]}. This is the maximal-length polynomial x^8+x^6+x^5+x^4+1 with period 255. 0x00 is the lock-up word and is never a valid seed.
- Registers: state, prediction P (8 b), run counter (4 b), error counter.
- States:
  - HUNT: on valid w≠0, set P←next(w) and run←0, go to VERIFY. On w=0, stay in HUNT.
  - VERIFY, on valid w:
    - w=P: P←next(w), run←run+1. If run+1=LOCK_COUNT, go to LOCKED and set run←0.
    - w≠P, w≠0: reseed P←next(w), run←0, stay in VERIFY.
    - w≠P, w=0: go to HUNT.
  - LOCKED, on valid w: P←next(P) always, so a received word never reseeds.
    - w=P: run←0.
    - w≠P: error pulse, error count +1 (saturating at 2^ERRWIDTH−1), run←run+1. If run+1=UNLOCK_COUNT, go to HUNT.
- Valid low: no register changes; error pulse low.
- Clear low has priority over increment in the same cycle: the count becomes 0, but the error pulse still fires. Clear does not affect state or lock.
- locked_OutHigh = (state==LOCKED), registered.

## Timing
- Reset values: state HUNT, P 0x00, run 0, locked 0, error 0, errcount 0. Reset mid-stream drops lock immediately and asynchronously.
- All outputs are registered. A word sampled on edge k updates its outputs after edge k, visible in cycle k+1.
- Lock latency: from the seed word, LOCK_COUNT further correct valid words. locked rises in the cycle after the last of these is sampled.
- Unlock: locked falls in the cycle after the UNLOCK_COUNT-th consecutive mismatch. That mismatch still pulses error and increments the count.
- Gaps (valid low) anywhere are transparent and do not break runs.
- Counter saturation: at the maximum value, further mismatches keep the count unchanged but still pulse error.

## Structure
- Shared package sc_pscheck_pkg holds:
  - State encoding constants: HUNT=2'b00, VERIFY=2'b01, LOCKED=2'b10.
  - Polynomial tap constant 8'hB8 (bits 7,5,4,3).
  - The next-word function, also reused by generator-side testbenches.
- One sub-module: sc_satcounter (parameter width; ports clear, increment, value), instantiated for the error count.
- FSM, prediction register and run counter stay in sc_pscheck.

## Test plan
All cases use LOCK_COUNT=4, UNLOCK_COUNT=3 unless stated.
- Lock: reset, then stream 0x01,0x02,0x04,0x08,0x11 with valid high → locked=1 from the cycle after 0x11; error never pulses; errcount=0.
- Single error: after lock, send 0x00 where 0x23 is due, then 0x47 → one error pulse, errcount=1, still locked; 0x47 is accepted as correct.
- Loss of lock: after lock, send three words ≠ prediction → errcount=3, locked falls after the third, state HUNT. Resend a correct run → relocks.
- Bad seed and gaps: in HUNT, send 0x00 repeatedly → stays in HUNT. Then 0x01, then alternate valid low and high across 0x02..0x11 → locks on the same count.
- Clear/saturation: with ERRWIDTH=2, cause 5 mismatches with UNLOCK_COUNT=15 → count stops at 3. Assert clear together with a mismatch → count 0, error pulse high.
- Async reset mid-lock: assert reset between edges → locked, error and errcount go to 0 immediately. After release, state HUNT.
